// File: rtl/chargepump_multi_if.sv
// Control/status bundle of the multi-channel charge-pump driver.
// The master side sets enables and timing; the slave side drives the pump pins.
interface chargepump_multi_if #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8,
    parameter int DEAD_WIDTH = 4
);
    logic [CHANNELS-1:0]   enable;
    logic [WIDTH-1:0]      period;
    logic [DEAD_WIDTH-1:0] dead_time;
    logic [CHANNELS-1:0]   cp_high;
    logic [CHANNELS-1:0]   cp_low;
    logic [CHANNELS-1:0]   active;

    modport master (
        output enable, period, dead_time,
        input  cp_high, cp_low, active
    );

    modport slave (
        input  enable, period, dead_time,
        output cp_high, cp_low, active
    );
endinterface

// File: rtl/chargepump_multi.sv
// Bootstrap charge-pump driver: a shared half-period timebase feeding per-channel
// complementary high/low FSMs with dead time; odd channels run in anti-phase.
module chargepump_multi #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 8,
    parameter int DEAD_WIDTH = 4
) (
    input logic               clk,
    input logic               reset,
    chargepump_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DEAD} state_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             tick;

    // Compare with >= so a period lowered below cnt wraps at once instead of at 2^WIDTH.
    always_comb begin
        tick    = (cnt_q >= bus.period);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        phase_d = tick ? ~phase_q : phase_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic ODD = ((i % 2) == 1);

        state_e                state_q;
        logic [DEAD_WIDTH-1:0] dcnt_q;
        logic                  high_q, low_q, active_q;
        logic                  tgt;

        // Target uses the phase value being taken at this edge, so outputs align with the toggle.
        assign tgt = phase_d ^ ODD;

        // Pin flops are written together with the state they decode, keeping them glitch-free.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= IDLE;
                dcnt_q   <= '0;
                high_q   <= 1'b0;
                low_q    <= 1'b0;
                active_q <= 1'b0;
            end else if (!bus.enable[i]) begin
                state_q  <= IDLE;
                high_q   <= 1'b0;
                low_q    <= 1'b0;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tick) begin
                            state_q  <= tgt ? HIGH : LOW;
                            high_q   <= tgt;
                            low_q    <= ~tgt;
                            active_q <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (tick && !tgt) begin
                            state_q <= DEAD;
                            dcnt_q  <= bus.dead_time;
                            high_q  <= 1'b0;
                        end
                    end
                    LOW: begin
                        if (tick && tgt) begin
                            state_q <= DEAD;
                            dcnt_q  <= bus.dead_time;
                            low_q   <= 1'b0;
                        end
                    end
                    DEAD: begin
                        if (dcnt_q != '0) begin
                            dcnt_q <= dcnt_q - 1'b1;
                        end else begin
                            state_q <= tgt ? HIGH : LOW;
                            high_q  <= tgt;
                            low_q   <= ~tgt;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        high_q   <= 1'b0;
                        low_q    <= 1'b0;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.cp_high[i] = high_q;
        assign bus.cp_low[i]  = low_q;
        assign bus.active[i]  = active_q;
    end
endmodule
